// File: rtl/suro_ctrl_fsm_if.sv
// suro-v.1 control sequencer: shared types and the datapath-facing bus.
// The FSM uses the master modport and the datapath uses the slave modport.
package suro_pkg;
   typedef logic [6:0] opcode_t;

   localparam opcode_t OPC_LUI    = 7'b0110111;
   localparam opcode_t OPC_AUIPC  = 7'b0010111;
   localparam opcode_t OPC_JAL    = 7'b1101111;
   localparam opcode_t OPC_JALR   = 7'b1100111;
   localparam opcode_t OPC_BRANCH = 7'b1100011;
   localparam opcode_t OPC_LOAD   = 7'b0000011;
   localparam opcode_t OPC_STORE  = 7'b0100011;
   localparam opcode_t OPC_IMM    = 7'b0010011;
   localparam opcode_t OPC_OP     = 7'b0110011;
   localparam opcode_t OPC_SYS    = 7'b1110011;

   typedef enum logic [2:0] {
      ALUC_NONE,
      ALUC_PC_4,
      ALUC_PC_IMM,
      ALUC_RS1_IMM,
      ALUC_BRANCH_OP,
      ALUC_OPEXE
   } alu_ctrl_t;

   typedef struct packed {
      opcode_t   opcode;
      alu_ctrl_t alu_ctrl;
      logic      start;
      logic      rf_rs1;
      logic      rf_rs2;
      logic      save_rd;
      logic      save_f3;
      logic      save_pc_next;
      logic      save_br_target;
      logic      save_store_target;
      logic      update_instr;
      logic      update_pc;
      logic      update_cntr_data;
      logic      memop;
   } ctrl_t;
endpackage

interface suro_ctrl_fsm_if;
   import suro_pkg::*;

   opcode_t opcode;
   logic    done;
   logic    mem_ready;
   ctrl_t   ctrl;
   logic    rf_we;
   logic    mem_req;
   logic    mem_we;
   logic    retire;
   logic    trap;
   logic    alu_err;
   logic    mem_err;

   modport master (
      input  opcode, done, mem_ready,
      output ctrl, rf_we, mem_req, mem_we,
      output retire, trap, alu_err, mem_err
   );

   modport slave (
      output opcode, done, mem_ready,
      input  ctrl, rf_we, mem_req, mem_we,
      input  retire, trap, alu_err, mem_err
   );
endinterface

// File: rtl/suro_ctrl_fsm.sv
// suro-v.1 multi-cycle control sequencer.
// Moore control on state plus latched opcode; FETCH passes the live opcode.
module suro_ctrl_fsm
   import suro_pkg::*;
#(
   parameter int ALU_TIMEOUT = 64,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic            clk,
   input  logic            rst,
   suro_ctrl_fsm_if.master bus
);

   typedef enum logic [2:0] {
      FETCH, DECODE, RS2, EXEC, MEM, WB, NEXTPC, HALT
   } state_t;

   localparam int TMAX = (ALU_TIMEOUT > MEM_TIMEOUT) ?
                         ALU_TIMEOUT : MEM_TIMEOUT;
   localparam int CW   = $clog2(TMAX + 1);

   state_t        r_state;
   state_t        w_nstate;
   opcode_t       r_op;
   logic [CW-1:0] r_cnt;
   logic          r_trap;
   logic          r_alu_err;
   logic          r_mem_err;

   logic          w_legal;
   logic          w_multi;
   logic          w_alu_to;
   logic          w_mem_to;
   logic          w_wait;

   ctrl_t         w_ctrl;
   logic          w_rf_we;
   logic          w_mem_req;
   logic          w_mem_we;
   logic          w_retire;

   assign w_multi  = (r_op == OPC_OP) || (r_op == OPC_IMM);
   assign w_alu_to = (r_cnt == CW'(ALU_TIMEOUT - 1));
   assign w_mem_to = (r_cnt == CW'(MEM_TIMEOUT - 1));
   assign w_wait   = (w_nstate == r_state) &&
                     ((r_state == EXEC) || (r_state == MEM));

   // classify the incoming opcode as a supported RV32I major opcode
   always_comb begin
      w_legal = 1'b0;
      case (bus.opcode)
         OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
         OPC_BRANCH, OPC_LOAD, OPC_STORE,
         OPC_IMM, OPC_OP, OPC_SYS: w_legal = 1'b1;
         default:                  w_legal = 1'b0;
      endcase
   end

   // next-state sequencing, including the ALU and memory watchdogs
   always_comb begin
      w_nstate = r_state;
      unique case (r_state)
         FETCH: begin
            if (bus.mem_ready)
               w_nstate = w_legal ? DECODE : HALT;
         end
         DECODE: begin
            case (r_op)
               OPC_LUI:                       w_nstate = WB;
               OPC_OP, OPC_BRANCH, OPC_STORE: w_nstate = RS2;
               default:                       w_nstate = EXEC;
            endcase
         end
         RS2: w_nstate = EXEC;
         EXEC: begin
            if (w_multi) begin
               if (bus.done)
                  w_nstate = WB;
               else if (w_alu_to)
                  w_nstate = HALT;
            end else begin
               case (r_op)
                  OPC_BRANCH, OPC_JAL,
                  OPC_JALR:             w_nstate = NEXTPC;
                  OPC_LOAD, OPC_STORE:  w_nstate = MEM;
                  default:              w_nstate = WB;
               endcase
            end
         end
         MEM: begin
            if (bus.mem_ready)
               w_nstate = (r_op == OPC_STORE) ? NEXTPC : WB;
            else if (w_mem_to)
               w_nstate = HALT;
         end
         WB:      w_nstate = FETCH;
         NEXTPC:  w_nstate = FETCH;
         HALT:    w_nstate = HALT;
         default: w_nstate = FETCH;
      endcase
   end

   // state, latched opcode, wait counter and sticky error flags
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= FETCH;
         r_op      <= '0;
         r_cnt     <= '0;
         r_trap    <= 1'b0;
         r_alu_err <= 1'b0;
         r_mem_err <= 1'b0;
      end else begin
         r_state <= w_nstate;
         if (r_state == FETCH && bus.mem_ready)
            r_op <= bus.opcode;
         r_cnt <= w_wait ? r_cnt + 1'b1 : '0;
         if (r_state == FETCH && bus.mem_ready && !w_legal)
            r_trap <= 1'b1;
         if (r_state == EXEC && w_multi && !bus.done && w_alu_to)
            r_alu_err <= 1'b1;
         if (r_state == MEM && !bus.mem_ready && w_mem_to)
            r_mem_err <= 1'b1;
      end
   end

   // control bundle decode; everything held at zero while in reset
   always_comb begin
      w_ctrl    = '0;
      w_rf_we   = 1'b0;
      w_mem_req = 1'b0;
      w_mem_we  = 1'b0;
      w_retire  = 1'b0;
      if (!rst) begin
         w_ctrl.opcode = (r_state == FETCH) ? bus.opcode : r_op;
         unique case (r_state)
            FETCH: begin
               w_mem_req           = 1'b1;
               w_ctrl.update_instr = bus.mem_ready;
            end
            DECODE: begin
               w_ctrl.rf_rs1       = 1'b1;
               w_ctrl.save_rd      = 1'b1;
               w_ctrl.alu_ctrl     = ALUC_PC_4;
               w_ctrl.save_pc_next = 1'b1;
            end
            RS2: begin
               w_ctrl.rf_rs2 = 1'b1;
               if (r_op == OPC_BRANCH) begin
                  w_ctrl.alu_ctrl       = ALUC_PC_IMM;
                  w_ctrl.save_br_target = 1'b1;
                  w_ctrl.save_f3        = 1'b1;
               end
            end
            EXEC: begin
               w_ctrl.start = (r_cnt == '0);
               case (r_op)
                  OPC_OP, OPC_IMM:
                     w_ctrl.alu_ctrl = ALUC_OPEXE;
                  OPC_BRANCH:
                     w_ctrl.alu_ctrl = ALUC_BRANCH_OP;
                  OPC_LOAD:
                     w_ctrl.alu_ctrl = ALUC_RS1_IMM;
                  OPC_STORE: begin
                     w_ctrl.alu_ctrl          = ALUC_RS1_IMM;
                     w_ctrl.save_store_target = 1'b1;
                  end
                  OPC_JAL, OPC_AUIPC:
                     w_ctrl.alu_ctrl = ALUC_PC_IMM;
                  OPC_JALR:
                     w_ctrl.alu_ctrl = ALUC_RS1_IMM;
                  OPC_SYS:
                     w_ctrl.update_cntr_data = 1'b1;
                  default: ;
               endcase
               if (r_op == OPC_JAL || r_op == OPC_JALR)
                  w_ctrl.update_pc = 1'b1;
            end
            MEM: begin
               w_ctrl.memop = 1'b1;
               w_mem_req    = 1'b1;
               w_mem_we     = (r_op == OPC_STORE);
            end
            WB: begin
               w_rf_we  = 1'b1;
               w_retire = 1'b1;
               if (r_op != OPC_JAL && r_op != OPC_JALR) begin
                  w_ctrl.update_pc = 1'b1;
                  w_ctrl.alu_ctrl  = ALUC_PC_4;
               end
            end
            NEXTPC: begin
               w_retire = 1'b1;
               case (r_op)
                  OPC_BRANCH: begin
                     w_ctrl.alu_ctrl  = ALUC_BRANCH_OP;
                     w_ctrl.update_pc = 1'b1;
                  end
                  OPC_STORE: begin
                     w_ctrl.alu_ctrl  = ALUC_PC_4;
                     w_ctrl.update_pc = 1'b1;
                  end
                  OPC_JAL, OPC_JALR:
                     w_rf_we = 1'b1;
                  default: ;
               endcase
            end
            HALT: ;
            default: ;
         endcase
      end
   end

   assign bus.ctrl    = w_ctrl;
   assign bus.rf_we   = w_rf_we;
   assign bus.mem_req = w_mem_req;
   assign bus.mem_we  = w_mem_we;
   assign bus.retire  = w_retire;
   assign bus.trap    = r_trap;
   assign bus.alu_err = r_alu_err;
   assign bus.mem_err = r_mem_err;

endmodule

// File: tb/tb_suro_ctrl_fsm.sv
// Bench for suro_ctrl_fsm: per-cycle vector table plus
// hand sequences for trap, watchdogs and mid-operation reset.
module tb_suro_ctrl_fsm;
   import suro_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   suro_ctrl_fsm_if bus ();

   suro_ctrl_fsm #(
      .ALU_TIMEOUT(64),
      .MEM_TIMEOUT(255)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct {
      opcode_t   op;
      logic      d;
      logic      m;
      alu_ctrl_t alu;
      logic [7:0] s;
   } vec_t;

   vec_t v[$];
   int   checks = 0;
   int   errors = 0;

   // strobe order: rf_we mem_req mem_we retire start update_pc memop update_instr
   function automatic logic [7:0] strb();
      return {bus.rf_we, bus.mem_req, bus.mem_we, bus.retire,
              bus.ctrl.start, bus.ctrl.update_pc,
              bus.ctrl.memop, bus.ctrl.update_instr};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", nm, act, exp);
      end
   endtask

   task automatic add(input opcode_t op, input logic d, input logic m,
                      input alu_ctrl_t alu, input logic [7:0] s);
      vec_t e;
      e.op = op; e.d = d; e.m = m; e.alu = alu; e.s = s;
      v.push_back(e);
   endtask

   task automatic drive(input opcode_t op, input logic d, input logic m);
      bus.opcode    = op;
      bus.done      = d;
      bus.mem_ready = m;
      #1;
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      assert (!(bus.ctrl.rf_rs1 && bus.ctrl.rf_rs2) &&
              !(bus.ctrl.save_rd && bus.ctrl.save_f3) &&
              !(bus.ctrl.update_instr && bus.ctrl.save_br_target))
      else begin
         errors++;
         $display("FAIL excl got ctrl %h", bus.ctrl);
      end
   end

   initial begin
      logic ok;
      bus.opcode    = '0;
      bus.done      = 1'b0;
      bus.mem_ready = 1'b0;

      // ADDI: FETCH DECODE EXEC WB
      add(OPC_IMM, 1, 1, ALUC_NONE,   8'b0100_0001);
      add(OPC_IMM, 1, 1, ALUC_PC_4,   8'b0000_0000);
      add(OPC_IMM, 1, 1, ALUC_OPEXE,  8'b0000_1000);
      add(OPC_IMM, 1, 1, ALUC_PC_4,   8'b1001_0100);
      // SLL: done on 7th EXEC cycle, retire on cycle 11
      add(OPC_OP, 0, 1, ALUC_NONE,    8'b0100_0001);
      add(OPC_OP, 0, 1, ALUC_PC_4,    8'b0000_0000);
      add(OPC_OP, 0, 1, ALUC_NONE,    8'b0000_0000);
      add(OPC_OP, 0, 1, ALUC_OPEXE,   8'b0000_1000);
      for (int i = 0; i < 5; i++)
         add(OPC_OP, 0, 1, ALUC_OPEXE, 8'b0000_0000);
      add(OPC_OP, 1, 1, ALUC_OPEXE,   8'b0000_0000);
      add(OPC_OP, 0, 1, ALUC_PC_4,    8'b1001_0100);
      // BEQ via NEXTPC
      add(OPC_BRANCH, 1, 1, ALUC_NONE,      8'b0100_0001);
      add(OPC_BRANCH, 1, 1, ALUC_PC_4,      8'b0000_0000);
      add(OPC_BRANCH, 1, 1, ALUC_PC_IMM,    8'b0000_0000);
      add(OPC_BRANCH, 1, 1, ALUC_BRANCH_OP, 8'b0000_1000);
      add(OPC_BRANCH, 1, 1, ALUC_BRANCH_OP, 8'b0001_0100);
      // SW with MEM stalled 3 cycles
      add(OPC_STORE, 1, 1, ALUC_NONE,    8'b0100_0001);
      add(OPC_STORE, 1, 1, ALUC_PC_4,    8'b0000_0000);
      add(OPC_STORE, 1, 1, ALUC_NONE,    8'b0000_0000);
      add(OPC_STORE, 1, 1, ALUC_RS1_IMM, 8'b0000_1000);
      for (int i = 0; i < 3; i++)
         add(OPC_STORE, 1, 0, ALUC_NONE, 8'b0110_0010);
      add(OPC_STORE, 1, 1, ALUC_NONE,    8'b0110_0010);
      add(OPC_STORE, 1, 1, ALUC_PC_4,    8'b0001_0100);
      // LW with mem_ready delayed 2
      add(OPC_LOAD, 1, 1, ALUC_NONE,     8'b0100_0001);
      add(OPC_LOAD, 1, 1, ALUC_PC_4,     8'b0000_0000);
      add(OPC_LOAD, 1, 1, ALUC_RS1_IMM,  8'b0000_1000);
      add(OPC_LOAD, 1, 0, ALUC_NONE,     8'b0100_0010);
      add(OPC_LOAD, 1, 0, ALUC_NONE,     8'b0100_0010);
      add(OPC_LOAD, 1, 1, ALUC_NONE,     8'b0100_0010);
      add(OPC_LOAD, 1, 1, ALUC_PC_4,     8'b1001_0100);
      // JAL with one stalled FETCH
      add(OPC_JAL, 1, 0, ALUC_NONE,      8'b0100_0000);
      add(OPC_JAL, 1, 1, ALUC_NONE,      8'b0100_0001);
      add(OPC_JAL, 1, 1, ALUC_PC_4,      8'b0000_0000);
      add(OPC_JAL, 1, 1, ALUC_PC_IMM,    8'b0000_1100);
      add(OPC_JAL, 1, 1, ALUC_NONE,      8'b1001_0000);
      // LUI straight to WB
      add(OPC_LUI, 1, 1, ALUC_NONE,      8'b0100_0001);
      add(OPC_LUI, 1, 1, ALUC_PC_4,      8'b0000_0000);
      add(OPC_LUI, 1, 1, ALUC_PC_4,      8'b1001_0100);

      // reset state
      adv();
      adv();
      chk("rst_ctrl", 32'(bus.ctrl), 32'h0);
      chk("rst_strb", 32'(strb()), 32'h0);
      chk("rst_flags", 32'({bus.trap, bus.alu_err, bus.mem_err}), 32'h0);
      rst = 1'b0;

      foreach (v[i]) begin
         drive(v[i].op, v[i].d, v[i].m);
         chk($sformatf("vec%0d", i), 32'({bus.ctrl.alu_ctrl, strb()}),
             32'({v[i].alu, v[i].s}));
         adv();
      end

      // illegal opcode: trap, quiet HALT, rst clears
      drive(7'h7f, 1, 1);
      chk("ill_fetch", 32'(strb()), 32'h41);
      chk("ill_opc", 32'(bus.ctrl.opcode), 32'h7f);
      adv();
      chk("trap_set", 32'(bus.trap), 32'h1);
      ok = 1'b1;
      for (int i = 0; i < 20; i++) begin
         drive(OPC_IMM, 1, 1);
         if (bus.rf_we || bus.mem_req || bus.retire) ok = 1'b0;
         adv();
      end
      chk("halt_quiet", 32'(ok), 32'h1);
      chk("trap_sticky", 32'(bus.trap), 32'h1);
      rst = 1'b1;
      adv();
      chk("trap_clr", 32'(bus.trap), 32'h0);
      rst = 1'b0;
      drive(OPC_OP, 0, 0);
      chk("fetch_after_rst", 32'(strb()), 32'h40);

      // ALU watchdog
      drive(OPC_OP, 0, 1);
      adv();
      drive(OPC_LUI, 0, 1);
      chk("op_latched", 32'(bus.ctrl.opcode), 32'(OPC_OP));
      adv();
      adv();
      chk("to_start", 32'({bus.ctrl.start, bus.ctrl.alu_ctrl}),
          32'({1'b1, ALUC_OPEXE}));
      adv();
      chk("to_start_once", 32'(bus.ctrl.start), 32'h0);
      repeat (62) adv();
      chk("to_exec64", 32'({bus.alu_err, bus.ctrl.alu_ctrl}),
          32'({1'b0, ALUC_OPEXE}));
      adv();
      chk("alu_err", 32'({bus.alu_err, bus.ctrl.alu_ctrl}),
          32'({1'b1, ALUC_NONE}));
      rst = 1'b1;
      adv();
      rst = 1'b0;

      // memory watchdog
      drive(OPC_LOAD, 1, 1);
      adv();
      adv();
      adv();
      drive(OPC_LOAD, 1, 0);
      chk("mem1", 32'({bus.mem_req, bus.rf_we}), 32'h2);
      repeat (254) adv();
      chk("mem255", 32'({bus.mem_err, bus.mem_req}), 32'h1);
      adv();
      chk("mem_err", 32'({bus.mem_err, bus.mem_req}), 32'h2);
      rst = 1'b1;
      adv();
      rst = 1'b0;

      // reset in the middle of MEM
      drive(OPC_LOAD, 1, 1);
      adv();
      adv();
      adv();
      drive(OPC_LOAD, 1, 0);
      adv();
      chk("mid_mem", 32'({bus.mem_req, bus.ctrl.memop}), 32'h3);
      rst = 1'b1;
      adv();
      chk("rst_mem", 32'({bus.mem_req, bus.rf_we, bus.mem_err}), 32'h0);
      rst = 1'b0;
      drive(OPC_IMM, 1, 0);
      chk("rst_fetch", 32'(strb()), 32'h40);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
